pipe_if_stage: RTL

//  Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipelined CPU.

---
 rtl/pipe_if_stage.sv | 82 ++++++++
 1 files changed

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Also keeps a saturating count of load-use stall cycles.
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IFwip,
    input  logic             IDwir,
    input  logic [1:0]       IDpcsource,
    input  logic [31:0]      IDbpc,
    input  logic [31:0]      IDrpc,
    input  logic [31:0]      IDjpc,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      IFpc4,
    output logic [31:0]      IDinst,
    output logic [31:0]      IDpc4,
    output logic             IDvalid,
    output logic [CNT_W-1:0] stall_count
);

    logic [31:0] pc;
    logic [31:0] sel;
    logic [31:0] npc;
    logic        squash;

    assign imem_addr = pc;
    assign IFpc4     = pc + 32'd4;

    always_comb begin
        sel = IFpc4;
        unique case (IDpcsource)
            2'b00: sel = IFpc4;
            2'b01: sel = IDbpc;
            2'b10: sel = IDrpc;
            2'b11: sel = IDjpc;
        endcase
    end

    // Targets are forced word aligned
    assign npc = {sel[31:2], 2'b00};

    assign squash = !DELAY_SLOT && (IDpcsource != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (IFwip) begin
            pc <= npc;
        end
    end

    // A stall (IDwir=0) holds IF/ID even when a redirect is requested
    always_ff @(posedge clk) begin
        if (rst) begin
            IDinst  <= 32'd0;
            IDpc4   <= 32'd0;
            IDvalid <= 1'b0;
        end else if (IDwir) begin
            IDpc4 <= IFpc4;
            if (squash) begin
                IDinst  <= 32'd0;
                IDvalid <= 1'b0;
            end else begin
                IDinst  <= imem_rdata;
                IDvalid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (!IFwip && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
